// File: rtl/sprite_line_buffer_param.sv
// Double-buffered sprite line buffer: renderer draws one line while the composer reads/erases the other.
// Each line is BANKS interleaved simple dual-port RAMs so an erase clears BANKS pixels per cycle.
module sprite_line_buffer_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 640,
  parameter int unsigned BANKS      = 4,
  parameter int unsigned IDX_W      = $clog2(LINE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  active_render_buffer,
  input  logic [IDX_W-1:0]      renderer_rd_idx,
  output logic [DATA_WIDTH-1:0] renderer_rd_data,
  input  logic [IDX_W-1:0]      renderer_wr_idx,
  input  logic [DATA_WIDTH-1:0] renderer_wr_data,
  input  logic                  renderer_wr_en,
  input  logic [IDX_W-1:0]      composer_rd_idx,
  output logic [DATA_WIDTH-1:0] composer_rd_data,
  input  logic                  composer_erase_start,
  input  logic [DATA_WIDTH-1:0] erase_value,
  output logic                  erase_busy
);

  localparam int unsigned WORDS  = LINE_WIDTH / BANKS;
  localparam int unsigned BANK_W = $clog2(BANKS);
  localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE, ERASE} state_t;

  state_t                state_q, state_d;
  logic [WORD_W-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] erase_val_q, erase_val_d;
  logic                  pending_q, pending_d;
  logic                  active_q, active_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  erase_we;

  // Index decode for the three pixel ports
  logic                  ren_rd_ok, ren_wr_ok, cmp_rd_ok;
  logic [WORD_W-1:0]     ren_rd_word, ren_wr_word, cmp_rd_word;
  logic [BANK_W-1:0]     ren_rd_bank, ren_wr_bank, cmp_rd_bank;

  assign ren_rd_ok   = 32'(renderer_rd_idx) < LINE_WIDTH;
  assign ren_wr_ok   = 32'(renderer_wr_idx) < LINE_WIDTH;
  assign cmp_rd_ok   = 32'(composer_rd_idx) < LINE_WIDTH;
  assign ren_rd_bank = BANK_W'(renderer_rd_idx);
  assign ren_wr_bank = BANK_W'(renderer_wr_idx);
  assign cmp_rd_bank = BANK_W'(composer_rd_idx);
  assign ren_rd_word = ren_rd_ok ? WORD_W'(renderer_rd_idx >> BANK_W) : '0;
  assign ren_wr_word = ren_wr_ok ? WORD_W'(renderer_wr_idx >> BANK_W) : '0;
  assign cmp_rd_word = cmp_rd_ok ? WORD_W'(composer_rd_idx >> BANK_W) : '0;

  // Erase writes are suppressed in a reset cycle so an aborted erase stops cleanly
  assign erase_we = rst_n && (state_q == ERASE);

  // Per-line port steering: render line takes renderer traffic, the other takes composer/erase
  logic [BANKS-1:0]      line_we [2];
  logic [WORD_W-1:0]     line_wa [2];
  logic [DATA_WIDTH-1:0] line_wd [2];
  logic [WORD_W-1:0]     line_ra [2];

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      line_we[l] = '0;
      line_wa[l] = '0;
      line_wd[l] = '0;
      line_ra[l] = '0;
      if (active_q == 1'(l)) begin
        line_ra[l] = ren_rd_word;
        if (renderer_wr_en && ren_wr_ok) begin
          line_we[l] = BANKS'(1) << ren_wr_bank;
          line_wa[l] = ren_wr_word;
          line_wd[l] = renderer_wr_data;
        end
      end else begin
        line_ra[l] = cmp_rd_word;
        if (erase_we) begin
          line_we[l] = '1;
          line_wa[l] = cnt_q;
          line_wd[l] = erase_val_q;
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_data [2][BANKS];

  for (genvar l = 0; l < 2; l++) begin : g_line
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] ram [WORDS];
      logic [DATA_WIDTH-1:0] ram_q;

      always_ff @(posedge clk) begin
        if (line_we[l][b]) ram[line_wa[l]] <= line_wd[l];
        ram_q <= ram[line_ra[l]];
      end

      assign rd_data[l][b] = ram_q;
    end
  end

  // Read-side selects travel with the index so in-flight reads survive a swap
  logic                  ren_line_q, cmp_line_q, ren_ok_q, cmp_ok_q;
  logic [BANK_W-1:0]     ren_bank_q, cmp_bank_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ren_line_q <= 1'b0;
      cmp_line_q <= 1'b1;
      ren_ok_q   <= 1'b0;
      cmp_ok_q   <= 1'b0;
      ren_bank_q <= '0;
      cmp_bank_q <= '0;
    end else begin
      ren_line_q <= active_q;
      cmp_line_q <= ~active_q;
      ren_ok_q   <= ren_rd_ok;
      cmp_ok_q   <= cmp_rd_ok;
      ren_bank_q <= ren_rd_bank;
      cmp_bank_q <= cmp_rd_bank;
    end
  end

  assign renderer_rd_data = ren_ok_q ? rd_data[ren_line_q][ren_bank_q] : '0;
  assign composer_rd_data = cmp_ok_q ? rd_data[cmp_line_q][cmp_bank_q] : '0;

  // Erase sequencer and swap handshake; a swap only lands in an idle, non-starting cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    erase_val_d = erase_val_q;
    pending_d   = pending_q | swap_req;
    active_d    = active_q;
    ack_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (composer_erase_start) begin
          state_d     = ERASE;
          cnt_d       = '0;
          erase_val_d = erase_value;
        end else if (pending_d) begin
          active_d  = ~active_q;
          ack_d     = 1'b1;
          pending_d = 1'b0;
        end
      end
      ERASE: begin
        if (composer_erase_start) begin
          cnt_d       = '0;
          erase_val_d = erase_value;
        end else if (cnt_q == WORD_W'(WORDS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + WORD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ERASE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      erase_val_q <= '0;
      pending_q   <= 1'b0;
      active_q    <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      erase_val_q <= erase_val_d;
      pending_q   <= pending_d;
      active_q    <= active_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign swap_ack             = ack_q;
  assign active_render_buffer = active_q;
  assign erase_busy           = busy_q;

endmodule

// File: tb/tb_sprite_line_buffer_param.sv
// Directed bench for sprite_line_buffer_param: default build plus an 8-bit/320/8-bank build.
module tb_sprite_line_buffer_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst_n = 1'b0, swap_req = 1'b0, renderer_wr_en = 1'b0, composer_erase_start = 1'b0;
  logic        swap_ack, active_render_buffer, erase_busy;
  logic [9:0]  renderer_rd_idx = '0, renderer_wr_idx = '0, composer_rd_idx = '0;
  logic [15:0] renderer_wr_data = '0, erase_value = '0, renderer_rd_data, composer_rd_data;

  sprite_line_buffer_param dut (
    .clk(clk), .rst_n(rst_n), .swap_req(swap_req), .swap_ack(swap_ack),
    .active_render_buffer(active_render_buffer),
    .renderer_rd_idx(renderer_rd_idx), .renderer_rd_data(renderer_rd_data),
    .renderer_wr_idx(renderer_wr_idx), .renderer_wr_data(renderer_wr_data),
    .renderer_wr_en(renderer_wr_en),
    .composer_rd_idx(composer_rd_idx), .composer_rd_data(composer_rd_data),
    .composer_erase_start(composer_erase_start), .erase_value(erase_value),
    .erase_busy(erase_busy)
  );

  // Narrow instance: 8-bit pixels, 320 wide, 8 banks
  logic        rst8_n = 1'b0, swap_req8 = 1'b0, wr_en8 = 1'b0, erase_start8 = 1'b0;
  logic        swap_ack8, active8, busy8;
  logic [8:0]  rd_idx8 = '0, wr_idx8 = '0, crd_idx8 = '0;
  logic [7:0]  wr_data8 = '0, erase_value8 = '0, rd_data8, crd_data8;

  sprite_line_buffer_param #(.DATA_WIDTH(8), .LINE_WIDTH(320), .BANKS(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .swap_req(swap_req8), .swap_ack(swap_ack8),
    .active_render_buffer(active8),
    .renderer_rd_idx(rd_idx8), .renderer_rd_data(rd_data8),
    .renderer_wr_idx(wr_idx8), .renderer_wr_data(wr_data8),
    .renderer_wr_en(wr_en8),
    .composer_rd_idx(crd_idx8), .composer_rd_data(crd_data8),
    .composer_erase_start(erase_start8), .erase_value(erase_value8),
    .erase_busy(busy8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ren_read(input string tag, input logic [9:0] idx, input logic [15:0] exp);
    renderer_rd_idx = idx;
    tick();
    check(tag, 32'(renderer_rd_data), 32'(exp));
  endtask

  task automatic cmp_read(input string tag, input logic [9:0] idx, input logic [15:0] exp);
    composer_rd_idx = idx;
    tick();
    check(tag, 32'(composer_rd_data), 32'(exp));
  endtask

  // Counts consecutive sampled cycles with erase_busy high, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (erase_busy && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic start_erase(input logic [15:0] v);
    erase_value = v;
    composer_erase_start = 1'b1;
    tick();
    composer_erase_start = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  initial begin
    int n;
    int acks;

    // Reset state
    tick(); tick();
    check("rst_active", 32'(active_render_buffer), 32'd0);
    check("rst_ack", 32'(swap_ack), 32'd0);
    check("rst_busy", 32'(erase_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fill line A, then an out-of-range write that must be dropped
    renderer_wr_en = 1'b1;
    for (int i = 0; i < 640; i++) begin
      renderer_wr_idx  = 10'(i);
      renderer_wr_data = 16'(i);
      tick();
    end
    renderer_wr_idx  = 10'd640;
    renderer_wr_data = 16'hFFFF;
    tick();
    renderer_wr_en = 1'b0;

    ren_read("ren_rd0", 10'd0, 16'd0);
    ren_read("ren_rd1", 10'd1, 16'd1);
    ren_read("ren_rd2", 10'd2, 16'd2);
    ren_read("ren_rd3", 10'd3, 16'd3);
    ren_read("ren_rd639", 10'd639, 16'd639);
    ren_read("ren_rd640", 10'd640, 16'd0);

    // Idle swap: ack and toggle one cycle later, single pulse
    pulse_swap();
    check("swap1_ack", 32'(swap_ack), 32'd1);
    check("swap1_active", 32'(active_render_buffer), 32'd1);
    tick();
    check("swap1_ack_drop", 32'(swap_ack), 32'd0);
    cmp_read("cmp_rd5", 10'd5, 16'd5);

    // Fill line B (now render) with idx+1000
    renderer_wr_en = 1'b1;
    for (int i = 0; i < 640; i++) begin
      renderer_wr_idx  = 10'(i);
      renderer_wr_data = 16'(i + 1000);
      tick();
    end
    renderer_wr_en = 1'b0;

    // Erase composer line A with ABCD
    start_erase(16'hABCD);
    count_busy(n);
    check("erase_len", 32'(n), 32'd160);
    cmp_read("erase_rd0", 10'd0, 16'hABCD);
    cmp_read("erase_rd321", 10'd321, 16'hABCD);
    cmp_read("erase_rd639", 10'd639, 16'hABCD);
    ren_read("render_keep0", 10'd0, 16'd1000);
    ren_read("render_keep321", 10'd321, 16'd1321);
    ren_read("render_keep639", 10'd639, 16'd1639);

    // Swap requested mid-erase is held until the erase finishes, twice collapses to one
    start_erase(16'h1111);
    for (int i = 0; i < 10; i++) tick();
    pulse_swap();
    for (int i = 0; i < 5; i++) tick();
    pulse_swap();
    acks = 0;
    n = 0;
    while (erase_busy && n < 1000) begin
      acks += int'(swap_ack);
      n++;
      tick();
    end
    check("hold_no_ack", 32'(acks), 32'd0);
    check("hold_busy_done", 32'(erase_busy), 32'd0);
    check("hold_active", 32'(active_render_buffer), 32'd1);
    check("hold_ack_fall", 32'(swap_ack), 32'd0);
    tick();
    check("held_ack", 32'(swap_ack), 32'd1);
    check("held_active", 32'(active_render_buffer), 32'd0);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acks += int'(swap_ack);
    end
    check("held_single_ack", 32'(acks), 32'd0);
    check("held_active_stable", 32'(active_render_buffer), 32'd0);

    // Restart at word 80 on composer line B
    start_erase(16'h2222);
    for (int i = 0; i < 80; i++) tick();
    start_erase(16'h0001);
    count_busy(n);
    check("restart_len", 32'(n), 32'd160);
    cmp_read("restart_rd0", 10'd0, 16'd1);
    cmp_read("restart_rd321", 10'd321, 16'd1);
    cmp_read("restart_rd400", 10'd400, 16'd1);
    cmp_read("restart_rd639", 10'd639, 16'd1);

    // Reset at word 50 of an erase of line A (holding 1111)
    pulse_swap();
    check("swap3_active", 32'(active_render_buffer), 32'd1);
    start_erase(16'h7777);
    for (int i = 0; i < 50; i++) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(erase_busy), 32'd0);
    check("abort_active", 32'(active_render_buffer), 32'd0);
    check("abort_ack", 32'(swap_ack), 32'd0);
    rst_n = 1'b1;
    tick();
    ren_read("abort_rd0", 10'd0, 16'h7777);
    ren_read("abort_rd199", 10'd199, 16'h7777);
    ren_read("abort_rd200", 10'd200, 16'h1111);
    ren_read("abort_rd639", 10'd639, 16'h1111);
    check("abort_still_idle", 32'(erase_busy), 32'd0);

    // Narrow instance
    rst8_n = 1'b1;
    wr_en8 = 1'b1;
    wr_idx8 = 9'd319;
    wr_data8 = 8'h5A;
    tick();
    wr_en8 = 1'b0;
    rd_idx8 = 9'd319;
    tick();
    check("p8_rd319", 32'(rd_data8), 32'h5A);
    rd_idx8 = 9'd320;
    tick();
    check("p8_rd320", 32'(rd_data8), 32'h0);
    erase_value8 = 8'h3C;
    erase_start8 = 1'b1;
    tick();
    erase_start8 = 1'b0;
    n = 0;
    while (busy8 && n < 1000) begin
      n++;
      tick();
    end
    check("p8_erase_len", 32'(n), 32'd40);
    crd_idx8 = 9'd319;
    tick();
    check("p8_cmp_rd319", 32'(crd_data8), 32'h3C);
    rd_idx8 = 9'd319;
    tick();
    check("p8_render_keep", 32'(rd_data8), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
